// File: rtl/conv_pkg.sv
// Shared definitions for the convolution MAC processing element.
// Holds the PE state encoding, default element/accumulator widths and the
// clamp helper used by the saturating build (CONV_MAC_PE_SATURATE_EN).
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } pe_state_t;

    localparam int unsigned CONV_DATA_WIDTH = 2;
    localparam int unsigned CONV_ACC_WIDTH  = 16;
    localparam int unsigned SAT_WIDTH       = 64;

    // Clamp a wide signed value into the signed range of acc_width bits.
    function automatic logic signed [SAT_WIDTH-1:0] sat_acc(
        input logic signed [SAT_WIDTH-1:0] value,
        input int unsigned                 acc_width
    );
        logic signed [SAT_WIDTH-1:0] max_v;
        logic signed [SAT_WIDTH-1:0] min_v;
        max_v = (64'sd1 <<< (acc_width - 1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        if (value > max_v) begin
            return max_v;
        end else if (value < min_v) begin
            return min_v;
        end
        return value;
    endfunction

endpackage

// File: rtl/conv_lane_sum.sv
// Combinational LANES-wide signed multiply and sum of one input beat.
// Ports:
//   weight   : packed signed weights, lane 0 in LSBs
//   infmap   : packed signed activations, lane 0 in LSBs
//   beat_sum : exact signed sum of all lane products
module conv_lane_sum #(
    parameter int unsigned DATA_WIDTH = 2,
    parameter int unsigned LANES      = 4,
    parameter int unsigned SUM_WIDTH  = 2 * DATA_WIDTH + $clog2(LANES) + 1
) (
    input  logic [LANES*DATA_WIDTH-1:0] weight,
    input  logic [LANES*DATA_WIDTH-1:0] infmap,
    output logic signed [SUM_WIDTH-1:0] beat_sum
);

    localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;

    logic signed [DATA_WIDTH-1:0] w_lane;
    logic signed [DATA_WIDTH-1:0] a_lane;
    logic signed [PROD_WIDTH-1:0] prod;

    // Full-precision products, sign-extended before summing.
    always_comb begin
        beat_sum = '0;
        w_lane   = '0;
        a_lane   = '0;
        prod     = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            w_lane   = weight[i*DATA_WIDTH +: DATA_WIDTH];
            a_lane   = infmap[i*DATA_WIDTH +: DATA_WIDTH];
            prod     = PROD_WIDTH'(w_lane) * PROD_WIDTH'(a_lane);
            beat_sum = beat_sum + SUM_WIDTH'(prod);
        end
    end

endmodule

// File: rtl/conv_mac_pe.sv
// Sequential convolution MAC PE: accumulates KERNEL_BEATS beats of LANES
// weight/activation products on top of an incoming partial sum and presents
// the window result with valid/ready backpressure.
// Build option: define CONV_MAC_PE_SATURATE_EN to clamp the accumulator to
// the signed ACC_WIDTH range after every beat instead of wrapping.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   clear               : synchronous abort of the current window
//   in_valid / in_ready : input beat handshake (in_ready is combinational)
//   weight, infmap      : packed signed lane operands, lane 0 in LSBs
//   inpsum              : initial partial sum, sampled on a window's first beat
//   out_valid/out_ready : result handshake
//   outpsum             : accumulated window result
//   busy                : window partially accumulated
module conv_mac_pe
    import conv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = CONV_DATA_WIDTH,
    parameter int unsigned ACC_WIDTH    = CONV_ACC_WIDTH,
    parameter int unsigned LANES        = 4,
    parameter int unsigned KERNEL_BEATS = 9
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*DATA_WIDTH-1:0] weight,
    input  logic [LANES*DATA_WIDTH-1:0] infmap,
    input  logic signed [ACC_WIDTH-1:0] inpsum,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [ACC_WIDTH-1:0] outpsum,
    output logic                        busy
);

    localparam int unsigned CNT_WIDTH  = $clog2(KERNEL_BEATS) + 1;
    localparam int unsigned SUM_WIDTH  = 2 * DATA_WIDTH + $clog2(LANES) + 1;
    localparam int unsigned BASE_WIDTH = (ACC_WIDTH >= SUM_WIDTH) ? ACC_WIDTH : SUM_WIDTH;
    localparam int unsigned WIDE_WIDTH = BASE_WIDTH + $clog2(LANES) + 1;
    localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(KERNEL_BEATS - 1);

    pe_state_t                   state, state_d;
    logic [CNT_WIDTH-1:0]        count, count_d;
    logic signed [ACC_WIDTH-1:0] acc, acc_d;
    logic signed [ACC_WIDTH-1:0] outpsum_d;
    logic                        out_valid_d;
    logic                        busy_d;

    logic signed [SUM_WIDTH-1:0]  beat_sum;
    logic signed [WIDE_WIDTH-1:0] acc_base;
    logic signed [WIDE_WIDTH-1:0] acc_sum;
    logic signed [ACC_WIDTH-1:0]  acc_next;
    logic                         accept;

    conv_lane_sum #(
        .DATA_WIDTH (DATA_WIDTH),
        .LANES      (LANES),
        .SUM_WIDTH  (SUM_WIDTH)
    ) u_lane_sum (
        .weight   (weight),
        .infmap   (infmap),
        .beat_sum (beat_sum)
    );

    // A held result blocks new beats only until it is taken downstream.
    assign in_ready = (state != HOLD) || out_ready;
    assign accept   = in_valid && in_ready;

    // Next accumulator value; first beat of a window starts from inpsum.
    always_comb begin
        acc_base = (count == '0) ? WIDE_WIDTH'(inpsum) : WIDE_WIDTH'(acc);
        acc_sum  = acc_base + WIDE_WIDTH'(beat_sum);
`ifdef CONV_MAC_PE_SATURATE_EN
        acc_next = ACC_WIDTH'(sat_acc(SAT_WIDTH'(acc_sum), ACC_WIDTH));
`else
        acc_next = ACC_WIDTH'(acc_sum);
`endif
    end

    // Next-state and output decode.
    always_comb begin
        state_d     = state;
        count_d     = count;
        acc_d       = acc;
        outpsum_d   = outpsum;
        out_valid_d = out_valid;

        if (clear) begin
            state_d     = IDLE;
            count_d     = '0;
            acc_d       = '0;
            outpsum_d   = '0;
            out_valid_d = 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
            if (accept) begin
                acc_d = acc_next;
                if (count == LAST_BEAT) begin
                    outpsum_d   = acc_next;
                    out_valid_d = 1'b1;
                    count_d     = '0;
                    state_d     = HOLD;
                end else begin
                    count_d = count + CNT_WIDTH'(1);
                    state_d = ACCUM;
                end
            end
        end

        busy_d = (state_d == ACCUM);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            acc       <= '0;
            outpsum   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            count     <= count_d;
            acc       <= acc_d;
            outpsum   <= outpsum_d;
            out_valid <= out_valid_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_conv_mac_pe.sv
// Bench for conv_mac_pe: a default (16-bit) and an 8-bit accumulator instance
// share stimulus; a reference model predicts window results into a queue and
// a negedge monitor compares DUT outputs against it.
module tb_conv_mac_pe;

    localparam int KB = 9;

    typedef struct {
        longint o16;
        longint o8;
    } exp_t;

    logic              clk       = 1'b0;
    logic              reset     = 1'b1;
    logic              clear     = 1'b0;
    logic              in_valid  = 1'b0;
    logic              out_ready = 1'b1;
    logic [7:0]        weight    = '0;
    logic [7:0]        infmap    = '0;
    logic signed [15:0] inpsum   = '0;
    logic signed [7:0]  inpsum8;

    logic               in_ready, out_valid, busy;
    logic signed [15:0] outpsum;
    logic               in_ready8, out_valid8, busy8;
    logic signed [7:0]  outpsum8;

    int   n_checks = 0;
    int   n_fail   = 0;

    int     m_cnt     = 0;
    bit     m_pending = 1'b0;
    longint m_acc16   = 0;
    longint m_acc8    = 0;
    exp_t   q[$];

    assign inpsum8 = inpsum[7:0];

    always #5 clk = ~clk;

    conv_mac_pe u_dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .weight    (weight),
        .infmap    (infmap),
        .inpsum    (inpsum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .outpsum   (outpsum),
        .busy      (busy)
    );

    conv_mac_pe #(.ACC_WIDTH(8)) u_dut8 (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready8),
        .weight    (weight),
        .infmap    (infmap),
        .inpsum    (inpsum8),
        .out_valid (out_valid8),
        .out_ready (out_ready),
        .outpsum   (outpsum8),
        .busy      (busy8)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference arithmetic: reduce to w-bit signed by wrap or clamp.
    function automatic longint fold(input longint v, input int w);
        longint hi, lo, r;
`ifndef CONV_MAC_PE_SATURATE_EN
        longint m;
`endif
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -hi - 1;
`ifdef CONV_MAC_PE_SATURATE_EN
        r = (v > hi) ? hi : ((v < lo) ? lo : v);
`else
        m = longint'(1) <<< w;
        r = v % m;
        if (r < 0) r += m;
        if (r > hi) r -= m;
`endif
        return r;
    endfunction

    function automatic int lane(input logic [7:0] bus, input int i);
        logic signed [1:0] b;
        b = bus[i*2 +: 2];
        return int'(b);
    endfunction

    function automatic longint dot(input logic [7:0] w, input logic [7:0] a);
        longint s;
        s = 0;
        for (int i = 0; i < 4; i++) s += lane(w, i) * lane(a, i);
        return s;
    endfunction

    function automatic logic [7:0] rep(input int v);
        logic [7:0] r;
        for (int i = 0; i < 4; i++) r[i*2 +: 2] = 2'(v);
        return r;
    endfunction

    // Reference model: consumes handshakes at each rising edge.
    initial forever begin
        bit rdy;
        longint s;
        @(posedge clk);
        if (reset || clear) begin
            m_cnt = 0; m_pending = 1'b0; m_acc16 = 0; m_acc8 = 0;
            q.delete();
        end else begin
            rdy = !m_pending || out_ready;
            if (m_pending && out_ready) m_pending = 1'b0;
            if (in_valid && rdy) begin
                s = dot(weight, infmap);
                m_acc16 = fold(((m_cnt == 0) ? longint'(inpsum)  : m_acc16) + s, 16);
                m_acc8  = fold(((m_cnt == 0) ? longint'(inpsum8) : m_acc8)  + s, 8);
                if (m_cnt == KB - 1) begin
                    q.push_back('{o16: m_acc16, o8: m_acc8});
                    m_pending = 1'b1;
                    m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
        end
    end

    // Monitor: checks handshake flags every cycle and results against the queue.
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            chk("out_valid",  out_valid,  m_pending);
            chk("out_valid8", out_valid8, m_pending);
            chk("in_ready",   in_ready,   !m_pending || out_ready);
            chk("in_ready8",  in_ready8,  !m_pending || out_ready);
            chk("busy",       busy,       m_cnt != 0);
            chk("busy8",      busy8,      m_cnt != 0);
            if (out_valid) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL outpsum_unexpected: got %0d with no expected result at %0t", outpsum, $time);
                end else begin
                    chk("outpsum",  outpsum,  q[0].o16);
                    chk("outpsum8", outpsum8, q[0].o8);
                    if (out_ready && !clear) void'(q.pop_front());
                end
            end
        end
    end

    task automatic set_beat(input int w, input int a, input int ps, input bit v);
        weight   = rep(w);
        infmap   = rep(a);
        inpsum   = 16'(ps);
        in_valid = v;
    endtask

    task automatic send_beat(input int w, input int a, input int ps);
        bit done;
        done = 1'b0;
        set_beat(w, a, ps, 1'b1);
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            @(posedge clk);
            #2;
        end
        chk("beat_accept_in_time", done, 1);
        in_valid = 1'b0;
    endtask

    task automatic window(input int w, input int a, input int ps);
        for (int i = 0; i < KB; i++) send_beat(w, a, (i == 0) ? ps : ps + 7);
    endtask

    task automatic wait_out(input longint e16, input longint e8, input string nm);
        bit done;
        done = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (out_valid) begin
                done = 1'b1;
                chk({nm, "_16"}, outpsum, e16);
                chk({nm, "_8"},  outpsum8, e8);
            end
            @(posedge clk);
            #2;
        end
        chk({nm, "_seen"}, done, 1);
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_out_valid"}, out_valid, 0);
        chk({nm, "_outpsum"},   outpsum,   0);
        chk({nm, "_busy"},      busy,      0);
        chk({nm, "_out_valid8"}, out_valid8, 0);
        chk({nm, "_outpsum8"},   outpsum8,   0);
        chk({nm, "_busy8"},      busy8,      0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_checks);
        $fatal(1);
    end

    initial begin
        // Reset state.
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset_state");
        chk("reset_in_ready", in_ready, 1);
        @(posedge clk); #2;

        // Basic windows.
        window(1, 1, 5);
        wait_out(41, 41, "ones_inpsum5");
        window(-2, -2, 0);
`ifdef CONV_MAC_PE_SATURATE_EN
        wait_out(144, 127, "neg2_sq");
`else
        wait_out(144, -112, "neg2_sq");
`endif

        // Backpressure in HOLD, then back-to-back first beat.
        out_ready = 1'b0;
        window(1, 1, 0);
        set_beat(1, 1, 2, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_outpsum", outpsum, 36);
            @(posedge clk); #2;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", in_ready, 1);
        @(posedge clk); #2;
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_busy", busy, 1);
        chk("b2b_out_valid", out_valid, 0);
        @(posedge clk); #2;
        for (int i = 0; i < KB - 1; i++) send_beat(1, 1, 0);
        wait_out(38, 38, "b2b_window");

        // Clear mid-window.
        for (int i = 0; i < 4; i++) send_beat(1, 1, 7);
        clear = 1'b1;
        @(posedge clk); #2;
        clear = 1'b0;
        @(negedge clk);
        chk("clear_busy", busy, 0);
        chk("clear_out_valid", out_valid, 0);
        @(posedge clk); #2;
        window(1, -1, 0);
        wait_out(-36, -36, "after_clear");

        // Reset during HOLD.
        out_ready = 1'b0;
        window(1, 1, 0);
        @(negedge clk);
        chk("hold_before_reset", out_valid, 1);
        @(posedge clk); #2;
        reset = 1'b1;
        #1 check_reset_outputs("reset_in_hold");
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        out_ready = 1'b1;

        // Reset mid-ACCUM.
        for (int i = 0; i < 3; i++) send_beat(1, 1, 0);
        reset = 1'b1;
        #1 check_reset_outputs("reset_in_accum");
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        window(1, 1, 3);
        wait_out(39, 39, "after_reset");

        // Randomised traffic with backpressure and occasional clear.
        for (int c = 0; c < 600; c++) begin
            weight    = 8'($urandom);
            infmap    = 8'($urandom);
            inpsum    = 16'(int'($urandom_range(0, 200)) - 100);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            clear     = ($urandom_range(0, 59) == 0);
            @(posedge clk); #2;
        end
        clear = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #2;
        chk("drain_queue_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_mac_pe.md
Name: conv_mac_pe

Overview:
- Sequential, parametrised successor to the single-cycle convolution MAC PE.
- Each cycle it accepts a beat of LANES weight/activation pairs and sums their products.
- Accumulates KERNEL_BEATS beats on top of an incoming partial sum, then presents one output partial sum with valid/ready backpressure.
- Sits between the weight/infmap feeders and the psum chain of the convolution array.

Parameters:
- DATA_WIDTH, 2, signed width of each weight and infmap element.
- ACC_WIDTH, 16, signed width of inpsum, accumulator and outpsum.
- LANES, 4, products summed per accepted beat.
- KERNEL_BEATS, 9, beats per output window; must be >= 1.
- CNT_WIDTH, $clog2(KERNEL_BEATS)+1, beat counter width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- clear  in  1  synchronous abort of current window
- in_valid  in  1  input beat valid
- in_ready  out  1  PE can accept a beat
- weight  in  LANES*DATA_WIDTH  packed signed weights, lane 0 in LSBs
- infmap  in  LANES*DATA_WIDTH  packed signed activations, lane 0 in LSBs
- inpsum  in  ACC_WIDTH  signed initial partial sum, sampled on the first beat only
- out_valid  out  1  outpsum valid
- out_ready  in  1  downstream accepts outpsum
- outpsum  out  ACC_WIDTH  signed accumulated window result
- busy  out  1  window partially accumulated (state ACCUM)

Behaviour:
- Reset is asynchronous and active-high. State goes to IDLE. Accumulator, beat count, outpsum and out_valid all go to 0. busy is 0. in_ready is 1.
- Clock is the single clk domain.
- States:
  - IDLE: no beats held.
  - ACCUM: 1..KERNEL_BEATS-1 beats taken.
  - HOLD: result presented.
- Beat accept: in_valid && in_ready.
- in_ready = (state != HOLD) || out_ready. It is combinational from state and out_ready, with no path from in_valid.
- Beat sum: each product is weight[i]*infmap[i], full precision. Products are sign-extended and summed to ACC_WIDTH+$clog2(LANES)+1 bits.
- First beat (count==0): acc <= inpsum + beat_sum.
- Later beats: acc <= acc + beat_sum.
- Accepted beat with count==KERNEL_BEATS-1:
  - outpsum <= final value; out_valid <= 1; count <= 0; state -> HOLD.
  - Latency: outpsum is valid the cycle after the last beat is accepted.
- Otherwise an accepted beat increments count; state -> ACCUM.
- HOLD:
  - outpsum and out_valid are stable until out_ready.
  - On out_valid && out_ready, out_valid drops next cycle. State -> IDLE, or -> ACCUM/HOLD if a new first beat is accepted in the same cycle (back-to-back, no bubble).
- KERNEL_BEATS==1: every accepted beat yields outpsum = inpsum + beat_sum. ACCUM is never entered.
- Default arithmetic wraps modulo 2^ACC_WIDTH; the result is truncated to ACC_WIDTH each beat.
- clear has priority over beat accept and output handshake. Next cycle: state IDLE, count 0, acc 0, out_valid 0, outpsum 0. A pending output is discarded.
- in_valid deasserted mid-window: acc and count hold. There is no timeout.
- Reset mid-window or in HOLD: immediate return to reset values. No output is produced.

Optional Feature:
- Macro: CONV_MAC_PE_SATURATE_EN.
- Defined: after each beat, the full-precision sum is clamped to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1] before being stored. Clamping applies on the first beat too (inpsum + beat_sum).
- Undefined: wrap-around as above, and no clamp logic is synthesised.
- Ports and latency are identical in both builds.

Decomposition:
- Shared package conv_pkg holds:
  - state enum pe_state_t {IDLE, ACCUM, HOLD};
  - default DATA_WIDTH/ACC_WIDTH localparams;
  - a saturate function sat_acc(wide value, ACC_WIDTH).
- One sub-module: conv_lane_sum. It is a combinational LANES-wide multiply plus adder tree producing beat_sum, and is parametrised by DATA_WIDTH and LANES.
- Control FSM, counter and accumulator stay in conv_mac_pe.

Test Plan:
- Defaults; inpsum=5; 9 beats with all weights=1, infmap=1 -> one output, outpsum=41, out_valid the cycle after beat 9.
- All weights=-2, infmap=-2 (16 per beat); 9 beats, inpsum=0 -> outpsum=144.
- ACC_WIDTH=8, same stimulus as above -> outpsum=-112 without CONV_MAC_PE_SATURATE_EN; outpsum=127 with it.
- out_ready held low 5 cycles in HOLD -> in_ready=0 and outpsum stable for 5 cycles. When out_ready rises with in_valid=1, the first beat of the next window is accepted in that same cycle.
- clear after 4 beats, then a full window of weights=1, infmap=-1, inpsum=0 -> outpsum=-36, with no contribution from the aborted beats.
- Assert reset during HOLD and mid-ACCUM -> out_valid=0, outpsum=0, busy=0 immediately. The next full window (inpsum=3, all products 1) -> outpsum=39.
